video_pattern_gen: RTL

//  Synthesizable, parametrised video source. Produces the camera-style vsync/href/clken/data stream

---
 rtl/video_pattern_gen_if.sv | 32 +++
 rtl/video_pattern_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen_if.sv
// rtl/video_pattern_gen_if.sv - camera-style video stream bundle
//
// Purpose: groups the video stream and its position/frame side-band so a
// source and its sink connect through one port.
// Signals:
//   vid_vsync  - frame sync
//   vid_href   - active-line window
//   vid_clken  - pixel valid strobe
//   vid_data   - pixel, channel 0 in the LSBs (DATA_W bits)
//   x_pos      - pixel column of vid_data, valid with vid_clken
//   y_pos      - active line index
//   frame_cnt  - completed frames
// Modports: master drives everything, slave observes everything.
interface video_pattern_gen_if #(
  parameter int DATA_W = 24
);
  logic              vid_vsync;
  logic              vid_href;
  logic              vid_clken;
  logic [DATA_W-1:0] vid_data;
  logic [15:0]       x_pos;
  logic [15:0]       y_pos;
  logic [15:0]       frame_cnt;

  modport master (
    output vid_vsync, vid_href, vid_clken, vid_data, x_pos, y_pos, frame_cnt
  );

  modport slave (
    input vid_vsync, vid_href, vid_clken, vid_data, x_pos, y_pos, frame_cnt
  );
endinterface

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - parametrised camera-style video test-pattern source
//
// Purpose: emits vsync/href/clken/data frames with configurable blanking,
// pixel-gap emulation and four runtime-selectable patterns, and counts
// completed frames. Every output is a flop.
// Ports:
//   clk     - single clock
//   rst     - synchronous active-high reset
//   enable  - run request; a frame already started always completes
//   mode    - pattern select (0 bars, 1 ramp, 2 checker, 3 LFSR), latched at frame start
//   vid     - master modport: vid_vsync, vid_href, vid_clken, vid_data, x_pos, y_pos, frame_cnt
module video_pattern_gen #(
  parameter int IMG_HDISP   = 640,
  parameter int IMG_VDISP   = 480,
  parameter int H_BLANK     = 160,
  parameter int VSYNC_LINES = 2,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2,
  parameter int CH_NUM      = 3,
  parameter int CH_WIDTH    = 8,
  parameter int CLKEN_GAP   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          mode,
  video_pattern_gen_if.master vid
);
  localparam int HREF_LEN = IMG_HDISP * (CLKEN_GAP + 1);
  localparam int LINE_LEN = HREF_LEN + H_BLANK;
  localparam int HW       = $clog2(LINE_LEN);
  localparam int DW       = CH_NUM * CH_WIDTH;

  localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] HREF_END  = HW'(HREF_LEN);
  localparam logic [15:0]   SLOT_LAST = 16'(CLKEN_GAP);
  localparam logic [31:0]   LFSR_SEED = 32'hACE1_2468;
  localparam logic [31:0]   LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;            // cycle within the current line
  logic [15:0]     v_q, v_d;            // line within the current FSM phase
  logic [15:0]     slot_q, slot_d;      // cycle within the current pixel slot
  logic [15:0]     pix_q, pix_d;        // pixel index of the current slot
  logic [1:0]      mode_q, mode_d;
  logic            par_q, par_d;        // frame parity for the checker
  logic [31:0]     lfsr_q, lfsr_d;
  logic            vid_vsync_q, vid_vsync_d;
  logic            vid_href_q, vid_href_d;
  logic            vid_clken_q, vid_clken_d;
  logic [DW-1:0]   vid_data_q, vid_data_d;
  logic [15:0]     x_pos_q, x_pos_d;
  logic [15:0]     y_pos_q, y_pos_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic            line_end, last_line, frame_done, start_frame;
  logic [2:0]      bar;
  logic [CH_WIDTH-1:0] ch;

  function automatic logic [15:0] lines_of(input state_t s);
    case (s)
      S_VSYNC:  return 16'(VSYNC_LINES);
      S_VBACK:  return 16'(V_BACK);
      S_ACTIVE: return 16'(IMG_VDISP);
      S_VFRONT: return 16'(V_FRONT);
      default:  return 16'd1;
    endcase
  endfunction

  // Bar index 7 - floor(8x/HDISP), done as a comparator ladder so no divider is built.
  function automatic logic [2:0] bar_of(input logic [15:0] x);
    logic [2:0] n;
    n = 3'd7;
    for (int j = 1; j < 8; j++) begin
      if (32'(x) * 32'd8 >= 32'(j * IMG_HDISP)) n = n - 3'd1;
    end
    return n;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    slot_d      = slot_q;
    pix_d       = pix_q;
    mode_d      = mode_q;
    par_d       = par_q;
    lfsr_d      = lfsr_q;
    frame_cnt_d = frame_cnt_q;
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    vid_vsync_d = 1'b0;
    vid_href_d  = 1'b0;
    vid_clken_d = 1'b0;
    vid_data_d  = '0;
    line_end    = 1'b0;
    last_line   = 1'b0;
    frame_done  = 1'b0;
    start_frame = 1'b0;
    bar         = '0;
    ch          = '0;

    if (state_q == S_IDLE) begin
      start_frame = enable;
    end else begin
      line_end = (h_q == H_LAST);
      h_d      = line_end ? '0 : h_q + 1'b1;
      if (line_end) begin
        last_line = (v_q == lines_of(state_q) - 16'd1);
        v_d       = last_line ? '0 : v_q + 16'd1;
        if (last_line) begin
          case (state_q)
            S_VSYNC:  state_d = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: if (V_FRONT > 0) state_d = S_VFRONT; else frame_done = 1'b1;
            S_VFRONT: frame_done = 1'b1;
            default:  state_d = S_IDLE;
          endcase
        end
      end
    end

    // enable is only consulted at frame boundaries, so frames are never cut short.
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      state_d     = S_IDLE;
      start_frame = enable;
    end

    if (start_frame) begin
      state_d = S_VSYNC;
      h_d     = '0;
      v_d     = '0;
      mode_d  = mode;
      par_d   = frame_cnt_d[0];
      lfsr_d  = LFSR_SEED;
    end

    // Slot/pixel counters follow h_d so the registered outputs line up with it.
    if (h_d == '0) begin
      slot_d = '0;
      pix_d  = '0;
    end else if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      pix_d  = pix_q + 16'd1;
    end else begin
      slot_d = slot_q + 16'd1;
    end

    vid_vsync_d = (state_d == S_VSYNC);
    vid_href_d  = (state_d == S_ACTIVE) && (h_d < HREF_END);
    vid_clken_d = vid_href_d && (slot_d == '0);

    if (state_d == S_VSYNC)       y_pos_d = '0;
    else if (state_d == S_ACTIVE) y_pos_d = v_d;

    if (vid_clken_d) begin
      x_pos_d = pix_d;
      bar     = bar_of(pix_d);
      for (int k = 0; k < CH_NUM; k++) begin
        case (mode_q)
          2'd0:    ch = bar[2'(k % 3)] ? '1 : '0;
          2'd1:    ch = CH_WIDTH'(32'(pix_d) + 32'(y_pos_d) + 32'(k));
          2'd2:    ch = (pix_d[4] ^ y_pos_d[4] ^ par_q) ? '1 : '0;
          default: ch = lfsr_q[CH_WIDTH-1:0];
        endcase
        vid_data_d[k*CH_WIDTH +: CH_WIDTH] = ch;
      end
      if (mode_q == 2'd3) lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      slot_q      <= '0;
      pix_q       <= '0;
      mode_q      <= '0;
      par_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      vid_vsync_q <= 1'b0;
      vid_href_q  <= 1'b0;
      vid_clken_q <= 1'b0;
      vid_data_q  <= '0;
      x_pos_q     <= '0;
      y_pos_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      slot_q      <= slot_d;
      pix_q       <= pix_d;
      mode_q      <= mode_d;
      par_q       <= par_d;
      lfsr_q      <= lfsr_d;
      vid_vsync_q <= vid_vsync_d;
      vid_href_q  <= vid_href_d;
      vid_clken_q <= vid_clken_d;
      vid_data_q  <= vid_data_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vid.vid_vsync = vid_vsync_q;
  assign vid.vid_href  = vid_href_q;
  assign vid.vid_clken = vid_clken_q;
  assign vid.vid_data  = vid_data_q;
  assign vid.x_pos     = x_pos_q;
  assign vid.y_pos     = y_pos_q;
  assign vid.frame_cnt = frame_cnt_q;
endmodule
